// File: rtl/polaris_pkg.sv
// ============================================================================
// polaris_pkg: shared constants and types for the Polaris fetch front end.
// Rev 1.0
// ============================================================================
`default_nettype none

package polaris_pkg;

    localparam logic [1:0]  ISIZ_NONE            = 2'b00;
    localparam logic [1:0]  ISIZ_WORD            = 2'b10;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/polaris_sync_fifo.sv
// ============================================================================
// polaris_sync_fifo: power-of-two synchronous FIFO with flush and occupancy.
// Rev 1.0
// ============================================================================
`default_nettype none

module polaris_sync_fifo
    import polaris_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Flush wins over both push and pop; illegal pushes/pops are dropped here too.
    assign w_push = push_i & ~full_o  & ~flush_i;
    assign w_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) wptr_d = wptr_q + PW'(1);
            if (w_pop)  rptr_d = rptr_q + PW'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is intentionally unreset; occupancy guarantees stale words are never shown.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/polaris_fetch_queue.sv
// ============================================================================
// polaris_fetch_queue: sequential instruction prefetch queue with redirect/jam.
// Rev 1.0
// ============================================================================
`default_nettype none

module polaris_fetch_queue
    import polaris_pkg::*;
#(
    parameter int          AW           = 64,
    parameter int          DEPTH        = 4,
    parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   iack_i,
    input  logic [31:0]            idat_i,
    output logic [AW-1:0]          iadr_o,
    output logic [1:0]             isiz_o,
    output logic [31:0]            inst_o,
    output logic [AW-1:0]          inst_pc_o,
    output logic                   inst_valid_o,
    input  logic                   inst_take_i,
    input  logic                   redirect_i,
    input  logic [AW-1:0]          redirect_pc_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   jammed_o
);

    localparam int QW = AW + 32;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;

    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [QW-1:0] w_head;

    // Request is held low while in reset so no bus activity leaks out.
    assign w_req  = reset_i & (state_q == FETCH) & ~w_full;
    assign w_push = w_req & iack_i & ~redirect_i;
    assign w_pop  = inst_take_i & inst_valid_o & ~redirect_i;

    assign isiz_o       = w_req ? ISIZ_WORD : ISIZ_NONE;
    assign iadr_o       = w_req ? fetch_pc_q : '0;
    assign inst_valid_o = ~w_empty;
    assign inst_o       = inst_valid_o ? w_head[31:0]    : 32'h0;
    assign inst_pc_o    = inst_valid_o ? w_head[QW-1:32] : '0;
    assign jammed_o     = (state_q == HALT);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            FETCH: begin
                if (redirect_i && pc_misaligned(redirect_pc_i[1:0])) state_d = HALT;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        if (redirect_i)  fetch_pc_d = redirect_pc_i;
        else if (w_push) fetch_pc_d = fetch_pc_q + AW'(4);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_VECTOR[AW-1:0];
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    polaris_sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .wdata_i ({fetch_pc_q, idat_i}),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .rdata_o (w_head),
        .count_o (count_o),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_polaris_fetch_queue.sv
// ============================================================================
// tb_polaris_fetch_queue: directed and random checks against a queue model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_polaris_fetch_queue;

    localparam int          AW    = 64;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RV    = 64'hFFFF_FFFF_FFFF_FF00;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   iack_i;
    logic [31:0]            idat_i;
    logic [AW-1:0]          iadr_o;
    logic [1:0]             isiz_o;
    logic [31:0]            inst_o;
    logic [AW-1:0]          inst_pc_o;
    logic                   inst_valid_o;
    logic                   inst_take_i;
    logic                   redirect_i;
    logic [AW-1:0]          redirect_pc_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   jammed_o;

    polaris_fetch_queue #(
        .AW           (AW),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .iack_i        (iack_i),
        .idat_i        (idat_i),
        .iadr_o        (iadr_o),
        .isiz_o        (isiz_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .inst_take_i   (inst_take_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .count_o       (count_o),
        .jammed_o      (jammed_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: the queue is a list of {pc, word}; everything else is derived from it.
    logic [AW+31:0] mq[$];
    logic [AW-1:0]  m_pc;
    logic           m_jam;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = RV;
        m_jam = 1'b0;
    endtask

    function automatic logic model_req();
        return !m_jam && (mq.size() < DEPTH);
    endfunction

    task automatic compare_model();
        logic req, vld;
        req = model_req();
        vld = mq.size() > 0;
        check("isiz",   64'(isiz_o),       req ? 64'd2 : 64'd0);
        check("iadr",   64'(iadr_o),       req ? 64'(m_pc) : 64'd0);
        check("valid",  64'(inst_valid_o), 64'(vld));
        check("inst",   64'(inst_o),       vld ? 64'(mq[0][31:0]) : 64'd0);
        check("instpc", 64'(inst_pc_o),    vld ? 64'(mq[0][AW+31:32]) : 64'd0);
        check("count",  64'(count_o),      64'(mq.size()));
        check("jammed", 64'(jammed_o),     64'(m_jam));
    endtask

    task automatic model_clock();
        logic do_push, do_pop;
        if (redirect_i) begin
            mq.delete();
            m_pc = redirect_pc_i;
            if (redirect_pc_i[1:0] != 2'b00) m_jam = 1'b1;
        end else begin
            do_push = model_req() && iack_i;
            do_pop  = inst_take_i && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_pc, idat_i});
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    // Inputs are applied at negedge, the model advances at posedge, outputs compared at next negedge.
    task automatic step(input logic ack, input logic [31:0] dat, input logic take,
                        input logic redir, input logic [AW-1:0] rpc);
        iack_i        = ack;
        idat_i        = dat;
        inst_take_i   = take;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        @(posedge clk_i);
        model_clock();
        @(negedge clk_i);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        iack_i = 1'b0; inst_take_i = 1'b0; redirect_i = 1'b0;
        reset_i = 1'b0;
        #1;
        check("rst_isiz",  64'(isiz_o),       64'd0);
        check("rst_iadr",  64'(iadr_o),       64'd0);
        check("rst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst",  64'(inst_o),       64'd0);
        check("rst_pc",    64'(inst_pc_o),    64'd0);
        check("rst_jam",   64'(jammed_o),     64'd0);
        check("rst_count", 64'(count_o),      64'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        model_reset();
        #1;
        compare_model();
    endtask

    initial begin
        reset_i = 1'b0; iack_i = 1'b0; idat_i = '0; inst_take_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Request held stable while no ack
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, '0);
            check("hold_iadr", 64'(iadr_o), 64'hFFFF_FFFF_FFFF_FF00);
            check("hold_isiz", 64'(isiz_o), 64'd2);
            check("hold_vld",  64'(inst_valid_o), 64'd0);
        end

        // Fill the queue
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
        check("full_count", 64'(count_o),   64'd4);
        check("full_isiz",  64'(isiz_o),    64'd0);
        check("full_iadr",  64'(iadr_o),    64'd0);
        check("full_inst",  64'(inst_o),    64'h13);
        check("full_pc",    64'(inst_pc_o), 64'hFFFF_FFFF_FFFF_FF00);

        // One take re-opens a request at the next sequential PC
        step(1'b0, 32'h0, 1'b1, 1'b0, '0);
        check("take_isiz",  64'(isiz_o),    64'd2);
        check("take_iadr",  64'(iadr_o),    64'hFFFF_FFFF_FFFF_FF10);
        check("take_count", 64'(count_o),   64'd3);
        step(1'b1, 32'h0000_0093, 1'b0, 1'b0, '0);
        check("refill_cnt", 64'(count_o),   64'd4);

        // Queue of two, simultaneous push and pop
        step(1'b0, 32'h0, 1'b0, 1'b1, RV);
        check("flush_cnt",  64'(count_o),   64'd0);
        step(1'b1, 32'hA000_0001, 1'b0, 1'b0, '0);
        step(1'b1, 32'hA000_0002, 1'b0, 1'b0, '0);
        check("two_cnt",    64'(count_o),   64'd2);
        check("two_pc",     64'(inst_pc_o), 64'hFFFF_FFFF_FFFF_FF00);
        step(1'b1, 32'hA000_0003, 1'b1, 1'b0, '0);
        check("pp_cnt",     64'(count_o),   64'd2);
        check("pp_pc",      64'(inst_pc_o), 64'hFFFF_FFFF_FFFF_FF04);
        check("pp_inst",    64'(inst_o),    64'hA000_0002);

        // Redirect discards a concurrent ack
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 64'h0124);
        check("rd_cnt",     64'(count_o),      64'd0);
        check("rd_vld",     64'(inst_valid_o), 64'd0);
        check("rd_iadr",    64'(iadr_o),       64'h0124);
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, '0);
        check("rd_pc",      64'(inst_pc_o),    64'h0124);
        check("rd_inst",    64'(inst_o),       64'h1111_2222);

        // Misaligned redirect jams until reset
        step(1'b0, 32'h0, 1'b0, 1'b1, 64'h0126);
        for (int i = 0; i < 4; i++) begin
            check("jam",      64'(jammed_o),     64'd1);
            check("jam_isiz", 64'(isiz_o),       64'd0);
            check("jam_vld",  64'(inst_valid_o), 64'd0);
            step(1'b1, $urandom, 1'b1, (i == 2), 64'h0200);
        end
        do_reset();
        check("unjam",     64'(jammed_o), 64'd0);
        check("unjam_adr", 64'(iadr_o),   64'hFFFF_FFFF_FFFF_FF00);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic          r;
            logic [AW-1:0] rpc;
            r   = ($urandom_range(0, 99) < 4);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 9) != 0) rpc[1:0] = 2'b00;
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45, r, rpc);
            if (m_jam && ($urandom_range(0, 7) == 0)) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
